// File: rtl/cfg_reg_bank_if.sv
// fx bus bundle shared by the configuration register bank and its bus master.
// The master drives write/read strobes and addresses; the bank returns registered read data.
interface cfg_reg_bank_if #(
   parameter int DW = 8
);
   logic          fx_wr;
   logic [21:0]   fx_waddr;
   logic [DW-1:0] fx_data;
   logic          fx_rd;
   logic [21:0]   fx_raddr;
   logic [DW-1:0] fx_q;
   logic          fx_qv;

   modport master (
      output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
      input  fx_q, fx_qv
   );

   modport slave (
      input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
      output fx_q, fx_qv
   );
endinterface

// File: rtl/cfg_reg_bank.sv
// Double-buffered configuration register bank on the fx bus: shadow/active pairs with
// atomic commit/revert, sticky W1C status, saturating bus-error counter and registered reads.
module cfg_reg_bank #(
   parameter int                   NREG    = 8,
   parameter int                   DW      = 8,
   parameter logic [15:0]          BASE    = 16'h0080,
   parameter logic [NREG*DW-1:0]   RST_VAL = '0
) (
   input  logic               clk_sys,
   input  logic               rst_n,
   input  logic [5:0]         dev_id,
   cfg_reg_bank_if.slave      fx,
   input  logic [DW-1:0]      sts_set,
   output logic [NREG*DW-1:0] cfg_out,
   output logic               cfg_upd
);

   localparam logic [15:0] OFF_ID   = 16'h0000;
   localparam logic [15:0] OFF_STS  = 16'h0001;
   localparam logic [15:0] OFF_CTRL = 16'h0002;
   localparam logic [15:0] OFF_ERR  = 16'h0003;

   logic [DW-1:0]   shadow [NREG];
   logic [DW-1:0]   active [NREG];
   logic [DW-1:0]   sts;
   logic [DW-1:0]   err;
   logic            upd_pend;

   logic            wr_go;
   logic            rd_go;
   logic [15:0]     woff;
   logic [15:0]     roff;
   logic [NREG-1:0] w_sh_hit;
   logic            do_commit;
   logic            do_revert;
   logic            err_hit;
   logic            err_clr;
   logic [DW-1:0]   sts_clr;
   logic [DW-1:0]   rdata;

   assign woff  = fx.fx_waddr[15:0];
   assign roff  = fx.fx_raddr[15:0];
   assign wr_go = fx.fx_wr && (fx.fx_waddr[21:16] == dev_id);
   assign rd_go = fx.fx_rd && (fx.fx_raddr[21:16] == dev_id);

   always_comb begin
      w_sh_hit = '0;
      for (int i = 0; i < NREG; i++) begin
         w_sh_hit[i] = (woff == 16'(int'(BASE) + i));
      end
   end

   // Commit has priority when both control bits are written together.
   assign do_commit = wr_go && (woff == OFF_CTRL) && fx.fx_data[0];
   assign do_revert = wr_go && (woff == OFF_CTRL) && fx.fx_data[1] && !fx.fx_data[0];

   // Anything not writable counts as a bus error: ID, the active window and unmapped space.
   assign err_hit = wr_go && (woff != OFF_STS) && (woff != OFF_CTRL) &&
                    (woff != OFF_ERR) && !(|w_sh_hit);
   assign err_clr = wr_go && (woff == OFF_ERR);
   assign sts_clr = (wr_go && (woff == OFF_STS)) ? fx.fx_data : '0;

   always_comb begin
      rdata = '0;
      case (roff)
         OFF_ID:   rdata = {{(DW-6){1'b0}}, dev_id};
         OFF_STS:  rdata = sts;
         OFF_CTRL: rdata = '0;
         OFF_ERR:  rdata = err;
         default: begin
            for (int i = 0; i < NREG; i++) begin
               if (roff == 16'(int'(BASE) + i)) begin
                  rdata = shadow[i];
               end
               if (roff == 16'(int'(BASE) + 64 + i)) begin
                  rdata = active[i];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            shadow[i] <= RST_VAL[i*DW +: DW];
            active[i] <= RST_VAL[i*DW +: DW];
         end
      end else if (do_commit) begin
         for (int i = 0; i < NREG; i++) begin
            active[i] <= shadow[i];
         end
      end else if (do_revert) begin
         for (int i = 0; i < NREG; i++) begin
            shadow[i] <= active[i];
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (wr_go && w_sh_hit[i]) begin
               shadow[i] <= fx.fx_data;
            end
         end
      end
   end

   // A set pulse overrides a same-cycle W1C on the same bit.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sts <= '0;
         err <= '0;
      end else begin
         sts <= (sts & ~sts_clr) | sts_set;
         if (err_clr) begin
            err <= '0;
         end else if (err_hit && (err != {DW{1'b1}})) begin
            err <= err + 1'b1;
         end
      end
   end

   // cfg_upd trails the cfg_out change by one cycle, hence the extra pending stage.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         upd_pend  <= 1'b0;
         cfg_upd   <= 1'b0;
         fx.fx_q   <= '0;
         fx.fx_qv  <= 1'b0;
      end else begin
         upd_pend  <= do_commit || do_revert;
         cfg_upd   <= upd_pend;
         fx.fx_qv  <= rd_go;
         fx.fx_q   <= rd_go ? rdata : '0;
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_cfg_out
      assign cfg_out[g*DW +: DW] = active[g];
   end

endmodule
